// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-field layout for the ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1L  = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    DONE = 3'd5
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_LOAD = 4'b0000,
    OP_COPY = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_NEG  = 4'b0100,
    OP_INV  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_SHL  = 4'b1001,
    OP_SHR  = 4'b1010,
    OP_ASR  = 4'b1011
  } alu_op_t;

  localparam int INSTR_W = 10;
  localparam int OP_LSB  = 6;
  localparam int RX_LSB  = 3;
  localparam int RY_LSB  = 0;

  // Opcodes above ASR have no ALU meaning.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op > OP_ASR);
  endfunction

endpackage

// File: rtl/alu_sequencer_onehot_dec.sv
// Binary register select to one-hot strobe vector, gated by an enable.
module onehot_dec #(
  parameter int RSW  = 3,
  parameter int NREG = 8
) (
  input  logic [RSW-1:0]  sel_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM driving the ALU and register-file bus strobes.
// Optional illegal-opcode trap (Err port) enabled by ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG = 8,
  parameter int OPW  = 4,
  parameter int RSW  = 3
) (
  input  logic               CLKb,
  input  logic               Reset,
  input  logic               Exec,
  input  logic [INSTR_W-1:0] INSTR,
  output logic [OPW-1:0]     FN,
  output logic               Ain,
  output logic               Gin,
  output logic               Gout,
  output logic [NREG-1:0]    Rin,
  output logic [NREG-1:0]    Rout,
  output logic               ExtOut,
  output logic               Busy,
  output logic               Done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
 ,output logic               Err
`endif
);

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [OPW-1:0] ir_op, in_op;
  logic [RSW-1:0] ir_rx, ir_ry, rout_sel;
  logic           in_trap;
  logic           rin_en, rout_en;

  assign ir_op = ir_q[OP_LSB +: OPW];
  assign ir_rx = ir_q[RX_LSB +: RSW];
  assign ir_ry = ir_q[RY_LSB +: RSW];
  assign in_op = INSTR[OP_LSB +: OPW];

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign in_trap = op_is_illegal(in_op);
  assign Err     = (state_q == DONE) && op_is_illegal(ir_op);
`else
  assign in_trap = 1'b0;
`endif

  always_ff @(posedge CLKb) begin
    if (Reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (Exec) begin
          ir_d = INSTR;
          if (in_op == OP_LOAD) state_d = T1L;
          else if (in_trap)     state_d = DONE;
          else                  state_d = T1;
        end
      end
      T1L:     state_d = DONE;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes depend only on registered state and IR, so they are glitch-free for the ALU's negedge capture.
  always_comb begin
    FN       = '0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    ExtOut   = 1'b0;
    Done     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = ir_rx;
    case (state_q)
      T1L: begin
        ExtOut = 1'b1;
        rin_en = 1'b1;
      end
      T1: begin
        rout_en  = 1'b1;
        rout_sel = ir_ry;
        Ain      = 1'b1;
      end
      T2: begin
        rout_en = 1'b1;
        FN      = ir_op;
        Gin     = 1'b1;
      end
      T3: begin
        Gout   = 1'b1;
        rin_en = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign Busy = (state_q != IDLE);

  onehot_dec #(.RSW(RSW), .NREG(NREG)) u_rin_dec (
    .sel_i    (ir_rx),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  onehot_dec #(.RSW(RSW), .NREG(NREG)) u_rout_dec (
    .sel_i    (rout_sel),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

endmodule
